// File: rtl/dram_ctrl_pkg.sv
// Shared types and default parameters for the DRAM access sequencer.
package dram_ctrl_pkg;

  localparam int unsigned DEF_ADDR_W   = 8;
  localparam int unsigned DEF_LANES    = 4;
  localparam int unsigned DEF_STRIDE_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Lane counter width; a single lane still needs one bit.
  function automatic int unsigned cnt_w(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/dram_addr_gen.sv
// Per-lane address generator: loads a base, then adds the latched stride per step.
module dram_addr_gen #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned STRIDE_W = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [ADDR_W-1:0]   base,
  input  logic [STRIDE_W-1:0] stride_in,
  input  logic                step,
  output logic [ADDR_W-1:0]   addr
);

  logic [ADDR_W-1:0]   addr_q,   addr_d;
  logic [STRIDE_W-1:0] stride_q, stride_d;

  // Accumulate instead of k*stride; the adder wraps modulo 2^ADDR_W.
  always_comb begin
    addr_d   = addr_q;
    stride_d = stride_q;
    if (load) begin
      addr_d   = base;
      stride_d = stride_in;
    end else if (step) begin
      addr_d = addr_q + ADDR_W'(stride_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      stride_q <= '0;
    end else begin
      addr_q   <= addr_d;
      stride_q <= stride_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/dram_seq_ctrl.sv
// Issues one DRAM access per lane (one-hot enable, strided or shared address),
// then pulses done; supports abort and back-to-back starts.
module dram_seq_ctrl
  import dram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned LANES    = DEF_LANES,
  parameter int unsigned STRIDE_W = DEF_STRIDE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                write_en,
  input  logic                strided,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [STRIDE_W-1:0] stride,
  input  logic                abort,
  output logic [LANES-1:0]    lane_en,
  output logic [ADDR_W-1:0]   dram_address,
  output logic                dram_we,
  output logic                busy,
  output logic                done
);

  localparam int unsigned    K_W    = cnt_w(LANES);
  localparam logic [K_W-1:0] K_LAST = K_W'(LANES - 1);

  state_e           state_q,   state_d;
  logic [K_W-1:0]   k_q,       k_d;
  logic [LANES-1:0] lane_en_q, lane_en_d;
  logic             we_q,      we_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic             strd_q,    strd_d;
  logic             load_c;
  logic             step_c;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    lane_en_d = lane_en_q;
    we_d      = we_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    strd_d    = strd_q;
    load_c    = 1'b0;
    step_c    = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Stores always use per-lane addressing.
          state_d   = ISSUE;
          k_d       = '0;
          lane_en_d = LANES'(1);
          we_d      = write_en;
          busy_d    = 1'b1;
          strd_d    = strided | write_en;
          load_c    = 1'b1;
        end else begin
          state_d   = IDLE;
          lane_en_d = '0;
          we_d      = 1'b0;
          busy_d    = 1'b0;
        end
      end
      ISSUE: begin
        if (abort) begin
          state_d   = IDLE;
          lane_en_d = '0;
          we_d      = 1'b0;
          busy_d    = 1'b0;
        end else if (k_q == K_LAST) begin
          state_d   = DONE;
          lane_en_d = '0;
          we_d      = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end else begin
          k_d       = K_W'(k_q + 1'b1);
          lane_en_d = lane_en_q << 1;
          step_c    = strd_q;
        end
      end
      default: begin
        state_d   = IDLE;
        lane_en_d = '0;
        we_d      = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      lane_en_q <= '0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      strd_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      lane_en_q <= lane_en_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      strd_q    <= strd_d;
    end
  end

  dram_addr_gen #(
    .ADDR_W   (ADDR_W),
    .STRIDE_W (STRIDE_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_c),
    .base      (base_addr),
    .stride_in (stride),
    .step      (step_c),
    .addr      (dram_address)
  );

  assign lane_en = lane_en_q;
  assign dram_we = we_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_dram_seq_ctrl.sv
// Randomized self-checking bench for dram_seq_ctrl against an arithmetic reference.
module tb_dram_seq_ctrl;

  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned LANES    = 4;
  localparam int unsigned STRIDE_W = 7;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic                write_en;
  logic                strided;
  logic [ADDR_W-1:0]   base_addr;
  logic [STRIDE_W-1:0] stride;
  logic                abort;
  logic [LANES-1:0]    lane_en;
  logic [ADDR_W-1:0]   dram_address;
  logic                dram_we;
  logic                busy;
  logic                done;

  int checks = 0;
  int errors = 0;

  dram_seq_ctrl #(
    .ADDR_W   (ADDR_W),
    .LANES    (LANES),
    .STRIDE_W (STRIDE_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .write_en     (write_en),
    .strided      (strided),
    .base_addr    (base_addr),
    .stride       (stride),
    .abort        (abort),
    .lane_en      (lane_en),
    .dram_address (dram_address),
    .dram_we      (dram_we),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic launch(input logic [7:0] b, input logic [6:0] s, input logic w, input logic st);
    @(negedge clk);
    start = 1'b1; base_addr = b; stride = s; write_en = w; strided = st; abort = 1'b0;
  endtask

  // Checks a sequence already accepted at the last rising edge; scrambles inputs while it runs.
  task automatic seq_check(input string name, input logic [7:0] b, input logic [6:0] s,
                           input logic w, input logic st, input int abort_at, input bit chain,
                           input logic [7:0] nb, input logic [6:0] ns, input logic nw, input logic nst);
    logic [7:0] ea;
    logic [3:0] el;
    bit aborted;
    aborted = 1'b0;
    for (int k = 0; k < int'(LANES); k++) begin
      @(negedge clk);
      el = 4'(1 << k);
      ea = (st | w) ? 8'(int'(b) + k * int'(s)) : b;
      checks++; if (lane_en !== el) begin errors++; $display("FAIL %s lane_en k=%0d got %b exp %b", name, k, lane_en, el); end
      checks++; if (dram_address !== ea) begin errors++; $display("FAIL %s addr k=%0d got %h exp %h", name, k, dram_address, ea); end
      checks++; if (dram_we !== w) begin errors++; $display("FAIL %s we k=%0d got %b exp %b", name, k, dram_we, w); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy k=%0d got %b exp 1", name, k, busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done k=%0d got %b exp 0", name, k, done); end
      base_addr = 8'($urandom); stride = 7'($urandom);
      write_en = 1'($urandom); strided = 1'($urandom);
      if (k == abort_at) begin
        abort = 1'b1; start = 1'b1; aborted = 1'b1;
        break;
      end
      abort = 1'b0;
      start = (k < int'(LANES) - 1) ? 1'($urandom) : 1'b0;
    end
    if (aborted) begin
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        checks++; if (lane_en !== 4'b0) begin errors++; $display("FAIL %s abort lane_en c=%0d got %b exp 0", name, c, lane_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s abort busy c=%0d got %b exp 0", name, c, busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s abort done c=%0d got %b exp 0", name, c, done); end
        abort = 1'b0; start = 1'b0;
      end
      return;
    end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s done pulse got %b exp 1", name, done); end
    checks++; if (lane_en !== 4'b0) begin errors++; $display("FAIL %s done lane_en got %b exp 0", name, lane_en); end
    checks++; if (dram_we !== 1'b0) begin errors++; $display("FAIL %s done we got %b exp 0", name, dram_we); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s done busy got %b exp 0", name, busy); end
    abort = 1'($urandom);
    if (chain) begin
      start = 1'b1; base_addr = nb; stride = ns; write_en = nw; strided = nst;
      return;
    end
    start = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s idle done got %b exp 0", name, done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s idle busy got %b exp 0", name, busy); end
    checks++; if (lane_en !== 4'b0) begin errors++; $display("FAIL %s idle lane_en got %b exp 0", name, lane_en); end
    abort = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; write_en = 1'b0; strided = 1'b0;
    base_addr = '0; stride = '0; abort = 1'b0;
    #2;
    checks++; if (lane_en !== 4'b0) begin errors++; $display("FAIL reset lane_en got %b exp 0", lane_en); end
    checks++; if (dram_address !== 8'h00) begin errors++; $display("FAIL reset addr got %h exp 00", dram_address); end
    checks++; if (dram_we !== 1'b0) begin errors++; $display("FAIL reset we got %b exp 0", dram_we); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done got %b exp 0", done); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_strided_read();
    launch(8'h10, 7'd5, 1'b0, 1'b1);
    seq_check("strided_read", 8'h10, 7'd5, 1'b0, 1'b1, -1, 1'b0, 8'h0, 7'd0, 1'b0, 1'b0);
  endtask

  task automatic test_nonstrided();
    launch(8'h40, 7'd7, 1'b0, 1'b0);
    seq_check("nonstrided", 8'h40, 7'd7, 1'b0, 1'b0, -1, 1'b0, 8'h0, 7'd0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap_write();
    launch(8'hFE, 7'd3, 1'b1, 1'b0);
    seq_check("wrap_write", 8'hFE, 7'd3, 1'b1, 1'b0, -1, 1'b0, 8'h0, 7'd0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    launch(8'h20, 7'd2, 1'b0, 1'b1);
    seq_check("b2b_first", 8'h20, 7'd2, 1'b0, 1'b1, -1, 1'b1, 8'h80, 7'd9, 1'b1, 1'b1);
    seq_check("b2b_second", 8'h80, 7'd9, 1'b1, 1'b1, -1, 1'b0, 8'h0, 7'd0, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    // abort alongside start in IDLE must not block the start
    @(negedge clk);
    start = 1'b1; abort = 1'b1; base_addr = 8'h33; stride = 7'd4; write_en = 1'b0; strided = 1'b1;
    seq_check("abort", 8'h33, 7'd4, 1'b0, 1'b1, 2, 1'b0, 8'h0, 7'd0, 1'b0, 1'b0);
    launch(8'h90, 7'd1, 1'b0, 1'b1);
    seq_check("after_abort", 8'h90, 7'd1, 1'b0, 1'b1, -1, 1'b0, 8'h0, 7'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    launch(8'h50, 7'd6, 1'b1, 1'b1);
    @(negedge clk);
    start = 1'b0;
    checks++; if (lane_en !== 4'b0001) begin errors++; $display("FAIL rst_mid lane0 got %b exp 0001", lane_en); end
    @(negedge clk);
    checks++; if (lane_en !== 4'b0010) begin errors++; $display("FAIL rst_mid lane1 got %b exp 0010", lane_en); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (lane_en !== 4'b0) begin errors++; $display("FAIL rst_mid lane_en got %b exp 0", lane_en); end
    checks++; if (dram_address !== 8'h00) begin errors++; $display("FAIL rst_mid addr got %h exp 00", dram_address); end
    checks++; if (dram_we !== 1'b0) begin errors++; $display("FAIL rst_mid we got %b exp 0", dram_we); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid done got %b exp 0", done); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid held done got %b exp 0", done); end
    rst_n = 1'b1;
    start = 1'b1; base_addr = 8'h77; stride = 7'h11; write_en = 1'b0; strided = 1'b1; abort = 1'b0;
    seq_check("after_reset", 8'h77, 7'h11, 1'b0, 1'b1, -1, 1'b0, 8'h0, 7'd0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] b, nb;
    logic [6:0] s, ns;
    logic       w, st, nw, nst;
    bit         launched, chain;
    int         ab;
    launched = 1'b0;
    b = 8'($urandom); s = 7'($urandom); w = 1'($urandom); st = 1'($urandom);
    for (int i = 0; i < 24; i++) begin
      if (!launched) launch(b, s, w, st);
      nb = 8'($urandom); ns = 7'($urandom); nw = 1'($urandom); nst = 1'($urandom);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LANES - 1)) : -1;
      chain = (ab < 0) && (i < 23) && 1'($urandom);
      seq_check("random", b, s, w, st, ab, chain, nb, ns, nw, nst);
      launched = chain;
      b = nb; s = ns; w = nw; st = nst;
    end
  endtask

  initial begin
    test_reset();
    test_strided_read();
    test_nonstrided();
    test_wrap_write();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_seq_ctrl.md
DRAM_SEQ_CTRL -- requirements
Module: dram_seq_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, sets the width of the DRAM address.
REQ-002 Parameter LANES, default 4, sets the number of bank/lane enables (min 1, max 16).
REQ-003 Parameter STRIDE_W, default 7, sets the width of the stride operand.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port start, input, 1 bit: request a new access sequence.
REQ-007 Port write_en, input, 1 bit: the sequence is a store (1) or a load (0).
REQ-008 Port strided, input, 1 bit: 1 gives per-lane stride addressing; 0 gives the same address for all lanes.
REQ-009 Port base_addr, input, ADDR_W bits: address of the first lane.
REQ-010 Port stride, input, STRIDE_W bits: address increment between lanes (unsigned).
REQ-011 Port abort, input, 1 bit: terminate the current sequence.
REQ-012 Port lane_en, output, LANES bits: one-hot lane enable, registered.
REQ-013 Port dram_address, output, ADDR_W bits: the address for the enabled lane, registered.
REQ-014 Port dram_we, output, 1 bit: write strobe, qualified by lane_en.
REQ-015 Port busy, output, 1 bit: high while a sequence is in progress.
REQ-016 Port done, output, 1 bit: one-cycle pulse marking sequence completion.

Function
REQ-017 The FSM SHALL have three states: IDLE, ISSUE and DONE.
REQ-018 In IDLE or DONE, start=1 SHALL latch base_addr, stride, write_en and the mode (strided forced to 1 when write_en=1), and enter ISSUE with lane index k=0.
REQ-019 In ISSUE, lane_en SHALL equal 1<<k, and dram_we SHALL equal the latched write_en.
REQ-020 In ISSUE, dram_address SHALL be (base + k*stride) mod 2^ADDR_W in strided mode, and base in non-strided mode.
REQ-021 dram_address SHALL be computed incrementally (previous address + stride) with no multiplier, and SHALL wrap silently.
REQ-022 ISSUE SHALL last exactly LANES cycles, with k incrementing each cycle, then transition to DONE.
REQ-023 DONE SHALL last one cycle: done=1, lane_en=0, dram_we=0; the FSM then goes to IDLE unless start=1 (back-to-back per REQ-018).
REQ-024 Latency: with start sampled at edge N, lane_en[0] SHALL be asserted in the cycle after edge N; done SHALL be asserted in the cycle after edge N+LANES.
REQ-025 busy SHALL be 1 in ISSUE and 0 in IDLE and DONE.
REQ-026 start in ISSUE SHALL be ignored and not queued.
REQ-027 abort=1 in ISSUE SHALL go to IDLE at the next edge with lane_en=0 and no done pulse; abort has priority over start in the same cycle.
REQ-028 abort in IDLE or DONE SHALL have no effect.
REQ-029 Input changes during ISSUE SHALL NOT affect the sequence in flight.

Reset
REQ-030 rst_n=0 SHALL force, asynchronously: state=IDLE, k=0, lane_en=0, dram_address=0, dram_we=0, busy=0, done=0.
REQ-031 Reset mid-ISSUE SHALL abandon the sequence, with no done pulse.
REQ-032 After reset release, the first start SHALL be accepted on the first rising edge.

Structure
REQ-033 Package dram_ctrl_pkg SHALL hold the state enum (IDLE/ISSUE/DONE) and the default values for ADDR_W, LANES and STRIDE_W.
REQ-034 The lane counter width SHALL be $clog2(LANES), with a minimum of 1.
REQ-035 One sub-module, dram_addr_gen (load base, accumulate stride, ADDR_W wrap), SHALL be used; the FSM SHALL stay in dram_seq_ctrl.

Verification
REQ-036 Read, strided: defaults, base=0x10, stride=5, start -> lane_en 0001/0010/0100/1000, addresses 0x10/0x15/0x1A/0x1F, dram_we=0, then a done pulse.
REQ-037 Non-strided read: base=0x40, stride=7, strided=0 -> all four lanes use address 0x40.
REQ-038 Wrap and write: base=0xFE, stride=3, write_en=1 -> addresses 0xFE/0x01/0x04/0x07, dram_we=1 on all four cycles.
REQ-039 Back-to-back and abort: start held during DONE -> a new sequence starts with no IDLE gap; abort on the lane-2 cycle -> IDLE, no done.
REQ-040 Reset mid-sequence: rst_n low on the lane-1 cycle -> all outputs 0 immediately; a start after release works normally.
